picobello_mcast_expander: RTL

- Sits on the narrow AXI AW path between a cluster/Cheshire initiator and a chimney that supports only unicast.
- Takes one request: an address plus its multicast mask, where the mask is the `user.mcast_mask` and a set bit means "don't-care address bit".
- Decodes the request against the multicast system address map and emits one unicast beat per selected cluster, with the destination `id_t` and a last flag.
- With `ExpandMcast=0` it decodes the request and passes it through as a single beat with the mask forwarded.

---
 rtl/picobello_pkg.sv | 93 +++++++++
 rtl/picobello_sam_lookup.sv | 26 ++
 rtl/picobello_mcast_expander.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/picobello_pkg.sv
// Shared types and the multicast system address map for the narrow AW
// multicast expander. The map describes a 4x4 cluster mesh (y at bits 18+:2,
// x at bits 20+:2, 256 KiB per cluster from 0x2000_0000) followed by one
// unicast-only peripheral region.
package picobello_pkg;

    localparam int unsigned NarrowAddrWidth = 48;
    localparam int unsigned NumClusters     = 16;
    localparam int unsigned SamNumRules     = NumClusters + 1;

    localparam logic [NarrowAddrWidth-1:0] ClusterBase = 48'h0000_2000_0000;
    localparam logic [NarrowAddrWidth-1:0] ClusterSpan = 48'h0000_0004_0000;
    localparam logic [NarrowAddrWidth-1:0] PeriphBase  = 48'h0000_0300_0000;
    localparam logic [NarrowAddrWidth-1:0] PeriphEnd   = 48'h0000_0400_0000;
    localparam logic [5:0] ClusterOffY = 6'd18;
    localparam logic [5:0] ClusterOffX = 6'd20;
    localparam logic [5:0] ClusterLenY = 6'd2;
    localparam logic [5:0] ClusterLenX = 6'd2;

    typedef logic [NarrowAddrWidth-1:0] user_mask_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } id_t;

    typedef struct packed {
        id_t id;
    } sam_idx_t;

    typedef struct packed {
        sam_idx_t                   idx;
        logic [NarrowAddrWidth-1:0] start_addr;
        logic [NarrowAddrWidth-1:0] end_addr;
        logic [5:0]                 offset_x;
        logic [5:0]                 len_x;
        logic [5:0]                 offset_y;
        logic [5:0]                 len_y;
    } sam_multicast_rule_t;

    typedef sam_multicast_rule_t [SamNumRules-1:0] sam_mcast_map_t;

    typedef enum logic [2:0] {
        MCAST_IDLE   = 3'd0,
        MCAST_DECODE = 3'd1,
        MCAST_SINGLE = 3'd2,
        MCAST_EMIT   = 3'd3,
        MCAST_ERR    = 3'd4
    } mcast_exp_state_e;

    // Rules 0..NumClusters-1 are clusters (multicast capable), the last one is
    // a peripheral with empty x/y fields.
    function automatic sam_mcast_map_t gen_sam_mcast();
        sam_mcast_map_t map;
        map = '0;
        for (int unsigned i = 0; i < NumClusters; i++) begin
            map[i].idx.id.x   = 3'(i / 4);
            map[i].idx.id.y   = 3'(i % 4);
            map[i].start_addr = ClusterBase
                              + (NarrowAddrWidth'(i / 4) << ClusterOffX)
                              + (NarrowAddrWidth'(i % 4) << ClusterOffY);
            map[i].end_addr   = map[i].start_addr + ClusterSpan;
            map[i].offset_x   = ClusterOffX;
            map[i].len_x      = ClusterLenX;
            map[i].offset_y   = ClusterOffY;
            map[i].len_y      = ClusterLenY;
        end
        map[SamNumRules-1].idx.id.x   = 3'd4;
        map[SamNumRules-1].idx.id.y   = 3'd0;
        map[SamNumRules-1].start_addr = PeriphBase;
        map[SamNumRules-1].end_addr   = PeriphEnd;
        return map;
    endfunction

    localparam sam_mcast_map_t SamMcast = gen_sam_mcast();

    // Bits of the address a rule allows to be don't-care (its x and y fields).
    function automatic user_mask_t mcast_field_mask(sam_multicast_rule_t r);
        user_mask_t one;
        user_mask_t fx;
        user_mask_t fy;
        one = {{(NarrowAddrWidth-1){1'b0}}, 1'b1};
        fx  = ((one << r.len_x) - one) << r.offset_x;
        fy  = ((one << r.len_y) - one) << r.offset_y;
        return fx | fy;
    endfunction

    // A mask is legal for a rule when it only touches that rule's x/y fields.
    function automatic bit mcast_mask_legal(sam_multicast_rule_t r, user_mask_t m);
        return (m & ~mcast_field_mask(r)) == {NarrowAddrWidth{1'b0}};
    endfunction

endpackage

// File: rtl/picobello_sam_lookup.sv
// Combinational first-match decoder over the multicast system address map.
module picobello_sam_lookup import picobello_pkg::*; #(
    parameter int unsigned NumRules = SamNumRules,
    localparam int unsigned RuleW   = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic [NarrowAddrWidth-1:0] addr_i,
    output logic                       hit_o,
    output logic [RuleW-1:0]           rule_o,
    output sam_idx_t                   idx_o
);

    // Scan from the highest rule down so the lowest matching index wins.
    always_comb begin
        hit_o  = 1'b0;
        rule_o = '0;
        idx_o  = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            hit_o  = hit_o | ((addr_i >= SamMcast[i].start_addr) && (addr_i < SamMcast[i].end_addr));
            rule_o = ((addr_i >= SamMcast[i].start_addr) && (addr_i < SamMcast[i].end_addr))
                   ? RuleW'(i) : rule_o;
            idx_o  = ((addr_i >= SamMcast[i].start_addr) && (addr_i < SamMcast[i].end_addr))
                   ? SamMcast[i].idx : idx_o;
        end
    end

endmodule

// File: rtl/picobello_mcast_expander.sv
// Expands one masked AW request into a sequence of unicast beats, one per
// selected cluster, for a chimney that only understands unicast. The output
// beat lives in registers; it only changes when accepted or on a new decode.
module picobello_mcast_expander import picobello_pkg::*; #(
    parameter int unsigned AddrWidth    = NarrowAddrWidth,
    parameter int unsigned NumRules     = SamNumRules,
    parameter int unsigned NumMcastEp   = NumClusters,
    parameter bit          ExpandMcast  = 1'b1,
    parameter int unsigned MaxMcastBits = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [AddrWidth-1:0]     req_mask_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [AddrWidth-1:0]     out_addr_o,
    output logic [AddrWidth-1:0]     out_mask_o,
    output logic [$bits(id_t)-1:0]   out_dst_o,
    output logic                     out_last_o,
    output logic                     out_err_o,
    output logic                     busy_o
);

    localparam int unsigned RuleW = (NumRules > 1) ? $clog2(NumRules) : 1;
    localparam logic [AddrWidth-1:0] AddrZero = {AddrWidth{1'b0}};
    localparam logic [AddrWidth-1:0] AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

    mcast_exp_state_e       state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d, mask_q, mask_d, e_q, e_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d, out_err_q, out_err_d;
    logic [AddrWidth-1:0]   out_addr_q, out_addr_d, out_mask_q, out_mask_d;
    id_t                    out_dst_q, out_dst_d;

    logic                   dec_hit, emit_hit, dec_err, emit_err, emit_last;
    logic [RuleW-1:0]       dec_rule, emit_rule;
    sam_idx_t               dec_idx, emit_idx;
    logic [AddrWidth-1:0]   e_next, cand;

    // Enumeration: the first beat uses e = 0, later beats the masked increment.
    assign e_next = (state_q == MCAST_DECODE) ? AddrZero : (((e_q | ~mask_q) + AddrOne) & mask_q);
    assign cand   = (addr_q & ~mask_q) | (e_next & mask_q);

    picobello_sam_lookup #(.NumRules(NumRules)) u_dec_lookup (
        .addr_i (addr_q),
        .hit_o  (dec_hit),
        .rule_o (dec_rule),
        .idx_o  (dec_idx)
    );

    picobello_sam_lookup #(.NumRules(NumRules)) u_emit_lookup (
        .addr_i (cand),
        .hit_o  (emit_hit),
        .rule_o (emit_rule),
        .idx_o  (emit_idx)
    );

    // The latched address never changes during a request, so the decode
    // lookup stays valid for the whole expansion.
    assign dec_err = !dec_hit
                   || ((32'(dec_rule) >= NumMcastEp) && (mask_q != AddrZero))
                   || !mcast_mask_legal(SamMcast[dec_rule], mask_q)
                   || (32'($countones(mask_q & mcast_field_mask(SamMcast[dec_rule]))) > MaxMcastBits);
    assign emit_err  = !emit_hit || (32'(emit_rule) >= NumMcastEp);
    assign emit_last = (e_next == (mask_q & mcast_field_mask(SamMcast[dec_rule])));

    // Next-state and next-beat selection; the beat only moves when accepted.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        e_d         = e_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_mask_d  = out_mask_q;
        out_dst_d   = out_dst_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        case (state_q)
            MCAST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    mask_d  = req_mask_i;
                    e_d     = AddrZero;
                    state_d = MCAST_DECODE;
                end else begin
                    state_d = MCAST_IDLE;
                end
            end
            MCAST_DECODE: begin
                out_valid_d = 1'b1;
                if (dec_err) begin
                    state_d    = MCAST_ERR;
                    out_addr_d = addr_q;
                    out_mask_d = AddrZero;
                    out_dst_d  = '0;
                    out_last_d = 1'b1;
                    out_err_d  = 1'b1;
                end else if ((mask_q == AddrZero) || !ExpandMcast) begin
                    state_d    = MCAST_SINGLE;
                    out_addr_d = addr_q;
                    out_mask_d = ExpandMcast ? AddrZero : mask_q;
                    out_dst_d  = dec_idx.id;
                    out_last_d = 1'b1;
                    out_err_d  = 1'b0;
                end else begin
                    state_d    = MCAST_EMIT;
                    e_d        = e_next;
                    out_addr_d = cand;
                    out_mask_d = AddrZero;
                    out_dst_d  = emit_idx.id;
                    out_last_d = emit_last;
                    out_err_d  = emit_err;
                end
            end
            MCAST_SINGLE, MCAST_ERR: begin
                if (out_ready_i) begin
                    state_d     = MCAST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            MCAST_EMIT: begin
                if (out_ready_i && out_last_q) begin
                    state_d     = MCAST_IDLE;
                    out_valid_d = 1'b0;
                end else if (out_ready_i) begin
                    e_d        = e_next;
                    out_addr_d = cand;
                    out_mask_d = AddrZero;
                    out_dst_d  = emit_idx.id;
                    out_last_d = emit_last;
                    out_err_d  = emit_err;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = MCAST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, request latch and output beat registers; reset drops everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MCAST_IDLE;
            addr_q      <= AddrZero;
            mask_q      <= AddrZero;
            e_q         <= AddrZero;
            out_valid_q <= 1'b0;
            out_addr_q  <= AddrZero;
            out_mask_q  <= AddrZero;
            out_dst_q   <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            e_q         <= e_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_mask_q  <= out_mask_d;
            out_dst_q   <= out_dst_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign req_ready_o = (state_q == MCAST_IDLE);
    assign busy_o      = (state_q != MCAST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_mask_o  = out_mask_q;
    assign out_dst_o   = out_dst_q;
    assign out_last_o  = out_last_q;
    assign out_err_o   = out_err_q;

endmodule
